// File: rtl/kernel_loader_pkg.sv
// rtl/kernel_loader_pkg.sv - shared defaults, bank size and loader state enum
//
// Purpose: defaults for the weight width, kernel count and taps per kernel,
// the derived bank size TOTAL (also consumed by the convolution datapath),
// and the loader FSM state type.
// Ports: none (package).

package kernel_loader_pkg;

  localparam int DATA_W_DEF      = 8;
  localparam int NUM_KERNELS_DEF = 8;
  localparam int K_TAPS_DEF      = 9;
  localparam int TOTAL           = NUM_KERNELS_DEF * K_TAPS_DEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } load_state_t;

endpackage

// File: rtl/kernel_loader.sv
// rtl/kernel_loader.sv - streams a full set of 3x3 kernel weights into a register bank
//
// Purpose: accepts NUM_KERNELS*K_TAPS weights (kernel-major, tap-minor) after a
// load_start request and presents the taps of the kernel chosen by k_sel with
// zero latency.
// Ports:
//   clk           - clock, rising edge
//   rst           - synchronous active-high reset
//   load_start    - request a full weight load (honoured only when idle)
//   s_data        - incoming weight
//   s_valid       - s_data is valid
//   s_ready       - loader accepts a weight this cycle (state decode only)
//   k_sel         - kernel index presented on k_values
//   k_values      - K_TAPS taps of the selected kernel
//   load_busy     - high while loading
//   load_done     - one-cycle pulse after the last weight is written
//   kernels_valid - bank holds a complete load

module kernel_loader
  import kernel_loader_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int NUM_KERNELS = NUM_KERNELS_DEF,
  parameter int K_TAPS      = K_TAPS_DEF,
  localparam int SEL_W      = (NUM_KERNELS > 1) ? $clog2(NUM_KERNELS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [SEL_W-1:0]  k_sel,
  output logic [DATA_W-1:0] k_values [0:K_TAPS-1],
  output logic              load_busy,
  output logic              load_done,
  output logic              kernels_valid
);

  localparam int BANK_DEPTH = NUM_KERNELS * K_TAPS;
  localparam int ADDR_W     = (BANK_DEPTH > 1) ? $clog2(BANK_DEPTH) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BANK_DEPTH - 1);

  load_state_t       state;
  load_state_t       state_d;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] bank [0:BANK_DEPTH-1];
  logic              accept;
  logic              last_accept;
  int                base;

  // s_ready depends on the state register alone, so s_valid never
  // reaches it combinationally.
  assign s_ready     = (state == LOAD);
  assign load_busy   = (state == LOAD);
  assign load_done   = (state == DONE);
  assign accept      = (state == LOAD) && s_valid;
  assign last_accept = accept && (addr == LAST_ADDR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (load_start) state_d = LOAD;
      LOAD:    if (last_accept) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr          <= '0;
      kernels_valid <= 1'b0;
      for (int i = 0; i < BANK_DEPTH; i++) begin
        bank[i] <= '0;
      end
    end else begin
      if ((state == IDLE) && load_start) begin
        addr          <= '0;
        kernels_valid <= 1'b0;
      end
      if (accept) begin
        bank[addr] <= s_data;
        // addr parks on the last entry; the next load clears it.
        if (last_accept) begin
          kernels_valid <= 1'b1;
        end else begin
          addr <= addr + ADDR_W'(1);
        end
      end
    end
  end

  // The multiply is by a constant, so it reduces to shift-add logic.
  // Out-of-range selects (non power-of-two kernel counts) read zero.
  always_comb begin
    base = int'(k_sel) * K_TAPS;
    for (int i = 0; i < K_TAPS; i++) begin
      k_values[i] = '0;
      if ((base + i) < BANK_DEPTH) begin
        k_values[i] = bank[ADDR_W'(base + i)];
      end
    end
  end

endmodule

// File: tb/tb_kernel_loader.sv
// tb/tb_kernel_loader.sv - self-checking bench for kernel_loader

module tb_kernel_loader;

  localparam int DW  = 8;
  localparam int NK  = 8;
  localparam int KT  = 9;
  localparam int TOT = NK * KT;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_start;
  logic [DW-1:0] s_data;
  logic          s_valid;
  logic          s_ready;
  logic [2:0]    k_sel;
  logic [DW-1:0] k_values [0:KT-1];
  logic          load_busy;
  logic          load_done;
  logic          kernels_valid;

  logic [DW-1:0] model [TOT];
  bit            model_kv;
  int            checks = 0;
  int            errors = 0;

  always #5 clk = ~clk;

  kernel_loader #(.DATA_W(DW), .NUM_KERNELS(NK), .K_TAPS(KT)) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .s_data(s_data),
    .s_valid(s_valid), .s_ready(s_ready), .k_sel(k_sel), .k_values(k_values),
    .load_busy(load_busy), .load_done(load_done), .kernels_valid(kernels_valid)
  );

  function automatic logic [DW-1:0] weight_of(input int mode, input int n);
    if (mode == 0) return DW'(n + 1);
    return DW'(8'hFF - n);
  endfunction

  // Drives one load scenario. mode selects the value sequence, stall_pct the
  // probability of an idle s_valid cycle, restart_at the weight index at which
  // load_start is re-pulsed (-1: never), abort_at the count of accepted
  // weights after which the stream is abandoned (-1: never).
  task automatic run_load(input int mode, input int stall_pct, input int restart_at,
                          input int abort_at, input string tag);
    int  n = 0;
    int  budget = 0;
    int  stalls = 0;
    bit  restarted = 0;
    bit  v;
    @(negedge clk);
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    model_kv = 0;
    checks++;
    if (kernels_valid !== 1'b0 || s_ready !== 1'b1 || load_busy !== 1'b1) begin
      errors++;
      $display("FAIL %s_enter_load kv=%b ready=%b busy=%b required kv=0 ready=1 busy=1",
               tag, kernels_valid, s_ready, load_busy);
    end
    while (n < TOT) begin
      if (abort_at >= 0 && n == abort_at) return;
      if (budget > 2000) begin
        errors++;
        $display("FAIL %s_timeout accepted=%0d required=%0d", tag, n, TOT);
        return;
      end
      checks++;
      if (s_ready !== 1'b1 || load_done !== 1'b0 || kernels_valid !== 1'b0) begin
        errors++;
        $display("FAIL %s_in_load n=%0d ready=%b done=%b kv=%b required ready=1 done=0 kv=0",
                 tag, n, s_ready, load_done, kernels_valid);
      end
      v = ($urandom_range(99) >= stall_pct);
      s_valid = v;
      s_data = v ? weight_of(mode, n) : DW'($urandom);
      load_start = (n == restart_at) && !restarted;
      if (load_start) restarted = 1;
      @(posedge clk);
      if (v) begin
        model[n] = weight_of(mode, n);
        n++;
      end else begin
        stalls++;
      end
      budget++;
      @(negedge clk);
      s_valid = 1'b0;
      load_start = 1'b0;
    end
    model_kv = 1;
    checks++;
    if (load_done !== 1'b1 || kernels_valid !== 1'b1 || s_ready !== 1'b0 || load_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_done_cycle done=%b kv=%b ready=%b busy=%b required 1 1 0 0",
               tag, load_done, kernels_valid, s_ready, load_busy);
    end
    checks++;
    if (budget !== TOT + stalls) begin
      errors++;
      $display("FAIL %s_latency cycles=%0d required=%0d", tag, budget, TOT + stalls);
    end
    @(negedge clk);
    checks++;
    if (load_done !== 1'b0 || kernels_valid !== 1'b1 || s_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s_back_to_idle done=%b kv=%b ready=%b required 0 1 0",
               tag, load_done, kernels_valid, s_ready);
    end
    for (int k = 0; k < NK; k++) begin
      k_sel = 3'(k);
      #1;
      for (int t = 0; t < KT; t++) begin
        checks++;
        if (k_values[t] !== model[k*KT+t]) begin
          errors++;
          $display("FAIL %s_bank k=%0d t=%0d got=%h required=%h",
                   tag, k, t, k_values[t], model[k*KT+t]);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    load_start = 1'b0;
    s_valid = 1'b0;
    s_data = '0;
    k_sel = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < TOT; i++) model[i] = '0;
    model_kv = 0;
    checks++;
    if (s_ready !== 1'b0 || kernels_valid !== 1'b0 || load_busy !== 1'b0 || load_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs ready=%b kv=%b busy=%b done=%b required all 0",
               s_ready, kernels_valid, load_busy, load_done);
    end
    for (int k = 0; k < NK; k++) begin
      k_sel = 3'(k);
      #1;
      for (int t = 0; t < KT; t++) begin
        checks++;
        if (k_values[t] !== '0) begin
          errors++;
          $display("FAIL reset_bank k=%0d t=%0d got=%h required=00", k, t, k_values[t]);
        end
      end
    end
  endtask

  task automatic test_full_load();
    logic [DW-1:0] exp_v;
    run_load(0, 0, -1, -1, "full");
    k_sel = 3'd0;
    #1;
    for (int t = 0; t < KT; t++) begin
      exp_v = DW'(t + 1);
      checks++;
      if (k_values[t] !== exp_v) begin
        errors++;
        $display("FAIL full_k0 t=%0d got=%h required=%h", t, k_values[t], exp_v);
      end
    end
    k_sel = 3'd7;
    #1;
    for (int t = 0; t < KT; t++) begin
      exp_v = DW'(8'h40 + t);
      checks++;
      if (k_values[t] !== exp_v) begin
        errors++;
        $display("FAIL full_k7 t=%0d got=%h required=%h", t, k_values[t], exp_v);
      end
    end
  endtask

  task automatic test_stalls();
    run_load(0, 45, -1, -1, "stall");
  endtask

  task automatic test_ignored_start();
    run_load(0, 20, 30, -1, "restart");
  endtask

  task automatic test_reset_mid_load();
    run_load(1, 10, -1, 40, "abort");
    @(negedge clk);
    rst = 1'b1;
    s_valid = 1'b1;
    load_start = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    s_valid = 1'b0;
    load_start = 1'b0;
    for (int i = 0; i < TOT; i++) model[i] = '0;
    model_kv = 0;
    checks++;
    if (s_ready !== 1'b0 || load_busy !== 1'b0 || kernels_valid !== 1'b0 || load_done !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle ready=%b busy=%b kv=%b done=%b required all 0",
               s_ready, load_busy, kernels_valid, load_done);
    end
    for (int k = 0; k < NK; k++) begin
      k_sel = 3'(k);
      #1;
      for (int t = 0; t < KT; t++) begin
        checks++;
        if (k_values[t] !== model[k*KT+t]) begin
          errors++;
          $display("FAIL abort_bank k=%0d t=%0d got=%h required=00", k, t, k_values[t]);
        end
      end
    end
    run_load(0, 25, -1, -1, "after_abort");
  endtask

  task automatic test_reload();
    logic [DW-1:0] exp_v;
    checks++;
    if (kernels_valid !== 1'b1) begin
      errors++;
      $display("FAIL reload_pre_kv got=%b required=1", kernels_valid);
    end
    run_load(1, 15, -1, -1, "reload");
    k_sel = 3'd3;
    #1;
    for (int t = 0; t < KT; t++) begin
      exp_v = DW'(8'hFF - (3 * KT + t));
      checks++;
      if (k_values[t] !== exp_v) begin
        errors++;
        $display("FAIL reload_k3 t=%0d got=%h required=%h", t, k_values[t], exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_stalls();
    test_ignored_start();
    test_reset_mid_load();
    test_reload();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
